// File: rtl/imem_loader.sv
// imem_loader: loads a program image byte-by-byte into a local instruction
// memory and serves a 10-byte combinational fetch window to the fetch stage.
// Optional feature macro: IMEM_CHECKSUM_EN adds an XOR checksum of the
// bytes accepted since the last load_start (load_csum is 0 without it).
module imem_loader #(
   parameter int MEM_BYTES = 1024,
   parameter int LEN_W     = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic [LEN_W-1:0] load_len,
   input  logic             load_valid,
   input  logic [7:0]       load_data,
   output logic             load_ready,
   output logic             load_done,
   output logic             load_err,
   output logic [7:0]       load_csum,
   input  logic [63:0]      fetch_pc,
   output logic [79:0]      fetch_bytes,
   output logic             fetch_err
);

   localparam int          IDX_W   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam int          ADDR_W  = $clog2(MEM_BYTES + 1);
   localparam logic [63:0] MEM_END = 64'(MEM_BYTES);
   localparam int          WIN     = 10;

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              xfer;
   logic              start_take;
   logic              len_bad;
   logic [64:0]       byte_addr;
   logic [7:0]        mem [MEM_BYTES];

   assign xfer       = (state_q == LOAD) && load_valid;
   assign start_take = load_start && (state_q != LOAD);
   assign len_bad    = (load_len == '0) || (64'(load_len) > MEM_END);

   // Next-state, address/remaining counters and status outputs.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      load_ready = 1'b0;
      load_done  = 1'b0;
      load_err   = 1'b0;
      unique case (state_q)
         LOAD: begin
            // load_start is deliberately ignored while a load is in flight.
            load_ready = 1'b1;
            if (load_valid) begin
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = DONE;
            end
         end
         default: begin
            load_done = (state_q == DONE);
            load_err  = (state_q == ERR);
            if (load_start) begin
               if (len_bad) begin
                  state_d = ERR;
               end else begin
                  state_d = LOAD;
                  addr_d  = '0;
                  rem_d   = load_len;
               end
            end
         end
      endcase
   end

   // State and counter registers; reset wins over start and transfers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
      end
   end

   // Program memory write port.
   always_ff @(posedge clk) begin
      // NOTE: the memory array has no reset; contents survive rst by design.
      if (!rst && xfer) mem[addr_q[IDX_W-1:0]] <= load_data;
   end

   // Fetch window: 64-bit addresses widened to 65 bits so pc+k never wraps.
   always_comb begin
      fetch_bytes = '0;
      byte_addr   = '0;
      for (int k = 0; k < WIN; k++) begin
         byte_addr = {1'b0, fetch_pc} + 65'(k);
         if (byte_addr < {1'b0, MEM_END}) fetch_bytes[8*k +: 8] = mem[byte_addr[IDX_W-1:0]];
      end
   end

   assign fetch_err = (state_q != DONE) || (fetch_pc >= MEM_END);

`ifdef IMEM_CHECKSUM_EN
   logic [7:0] csum_q;

   // Running XOR of accepted bytes, cleared when a new load is started.
   always_ff @(posedge clk) begin
      if (rst)             csum_q <= 8'h00;
      else if (start_take) csum_q <= 8'h00;
      else if (xfer)       csum_q <= csum_q ^ load_data;
   end

   assign load_csum = csum_q;
`else
   assign load_csum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized + directed stimulus for imem_loader. The driver
// pushes the expected per-cycle outputs (from an abstract model: flags,
// counters and a byte array) into a queue; a monitor on the falling edge
// pops and compares them against the DUT.
module tb_imem_loader;

   localparam int MEM = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [10:0] load_len;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_ready;
   logic        load_done;
   logic        load_err;
   logic [7:0]  load_csum;
   logic [63:0] fetch_pc;
   logic [79:0] fetch_bytes;
   logic        fetch_err;

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_len   (load_len),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_done  (load_done),
      .load_err   (load_err),
      .load_csum  (load_csum),
      .fetch_pc   (fetch_pc),
      .fetch_bytes(fetch_bytes),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ready;
      logic        done;
      logic        err;
      logic        ferr;
      logic [7:0]  csum;
      logic [79:0] bytes;
      logic [79:0] mask;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;

   // Reference model: what the loader should be doing, in plain terms.
   bit         m_loading, m_done, m_err;
   int         m_rem, m_addr;
   logic [7:0] m_csum;
   logic [7:0] m_mem [MEM];
   bit         m_known [MEM];

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bytes the window should show; unwritten in-range bytes are left unmasked.
   function automatic void model_fetch(input logic [63:0] pc, output logic [79:0] b,
                                       output logic [79:0] m);
      b = '0;
      m = '0;
      for (int k = 0; k < 10; k++) begin
         if (pc < 64'(MEM) && pc + 64'(k) < 64'(MEM)) begin
            if (m_known[int'(pc) + k]) begin
               b[8*k +: 8] = m_mem[int'(pc) + k];
               m[8*k +: 8] = 8'hFF;
            end
         end else begin
            m[8*k +: 8] = 8'hFF;
         end
      end
   endfunction

   // Monitor: compare whatever the driver predicted for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("load_ready", {79'b0, load_ready}, {79'b0, e.ready});
         check("load_done",  {79'b0, load_done},  {79'b0, e.done});
         check("load_err",   {79'b0, load_err},   {79'b0, e.err});
         check("fetch_err",  {79'b0, fetch_err},  {79'b0, e.ferr});
         check("load_csum",  {72'b0, load_csum},  {72'b0, e.csum});
         if (e.mask != '0) check("fetch_bytes", fetch_bytes & e.mask, e.bytes & e.mask);
      end
   end

   task automatic step(input bit r, input bit s, input logic [10:0] len, input bit v,
                       input logic [7:0] d, input logic [63:0] pc);
      exp_t e;
      rst        = r;
      load_start = s;
      load_len   = len;
      load_valid = v;
      load_data  = d;
      fetch_pc   = pc;
      if (chk_en) begin
         e.ready = m_loading;
         e.done  = m_done;
         e.err   = m_err;
         e.ferr  = !m_done || (pc >= 64'(MEM));
`ifdef IMEM_CHECKSUM_EN
         e.csum  = m_csum;
`else
         e.csum  = 8'h00;
`endif
         model_fetch(pc, e.bytes, e.mask);
         exp_q.push_back(e);
      end
      @(posedge clk);
      if (r) begin
         m_loading = 0; m_done = 0; m_err = 0; m_rem = 0; m_addr = 0; m_csum = 8'h00;
      end else if (m_loading) begin
         if (v) begin
            m_mem[m_addr]   = d;
            m_known[m_addr] = 1'b1;
            m_addr++;
            m_csum ^= d;
            m_rem--;
            if (m_rem == 0) begin
               m_loading = 0;
               m_done    = 1;
            end
         end
      end else if (s) begin
         m_csum = 8'h00;
         m_done = 0;
         if (len == 0 || int'(len) > MEM) begin
            m_err = 1;
         end else begin
            m_err = 0; m_loading = 1; m_addr = 0; m_rem = int'(len);
         end
      end
      #1;
   endtask

   task automatic idle(input int n, input logic [63:0] pc);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 11'd0, 1'b0, 8'h00, pc);
   endtask

   task automatic start(input logic [10:0] len);
      step(1'b0, 1'b1, len, 1'b0, 8'h00, 64'd0);
   endtask

   task automatic feed(input logic [7:0] d);
      step(1'b0, 1'b0, 11'd0, 1'b1, d, 64'd0);
   endtask

   function automatic logic [63:0] rand_pc();
      case ($urandom_range(0, 4))
         0:       return 64'($urandom_range(0, 15));
         1:       return 64'($urandom_range(1012, 1030));
         2:       return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 11));
         3:       return 64'($urandom_range(0, MEM - 1));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic logic [10:0] rand_len();
      case ($urandom_range(0, 9))
         0:       return 11'd0;
         1:       return 11'd1025;
         2:       return 11'd2047;
         3:       return 11'($urandom_range(100, 300));
         default: return 11'($urandom_range(1, 12));
      endcase
   endfunction

   initial begin
      m_loading = 0; m_done = 0; m_err = 0; m_rem = 0; m_addr = 0; m_csum = 8'h00;
      for (int i = 0; i < MEM; i++) m_known[i] = 1'b0;

      // Reset; outputs are checked once the reset edge has been seen.
      step(1'b1, 1'b0, 11'd0, 1'b0, 8'h00, 64'd0);
      chk_en = 1'b1;
      step(1'b1, 1'b1, 11'd3, 1'b1, 8'h55, 64'd0);
      idle(2, 64'd0);

      // Three-byte load with valid held high from the start cycle.
      step(1'b0, 1'b1, 11'd3, 1'b1, 8'h30, 64'd0);
      feed(8'h30); feed(8'hF2); feed(8'h0A);
      idle(3, 64'd0);
      idle(1, 64'd1);

      // Rejected lengths, then a valid load clears the error.
      start(11'd0);    idle(2, 64'd0);
      start(11'd1025); idle(2, 64'd0);
      start(11'd1);    feed(8'h5A); idle(2, 64'd0);

      // Checksum pattern 01,02,04.
      start(11'd3); feed(8'h01); feed(8'h02); feed(8'h04); idle(2, 64'd0);

      // Reset mid-load (with a transfer offered on the reset edge).
      start(11'd5); feed(8'hC1); feed(8'hC2);
      step(1'b1, 1'b0, 11'd0, 1'b1, 8'hC3, 64'd0);
      idle(2, 64'd0);
      start(11'd1); feed(8'hAB); idle(2, 64'd0);

      // Full-memory load, then boundary fetches.
      start(11'd1024);
      for (int i = 0; i < MEM; i++) feed(8'($urandom));
      idle(1, 64'd1020); idle(1, 64'd1014); idle(1, 64'd1023);
      idle(1, 64'd1024); idle(1, 64'd1025);
      idle(1, 64'hFFFF_FFFF_FFFF_FFFC); idle(1, 64'hFFFF_FFFF_FFFF_FFFF);

      // Mid-load start with another length, and gapped valid.
      start(11'd6);
      step(1'b0, 1'b1, 11'd2, 1'b1, 8'h11, 64'd0);
      step(1'b0, 1'b0, 11'd0, 1'b0, 8'h22, 64'd0);
      step(1'b0, 1'b1, 11'd9, 1'b1, 8'h33, 64'd0);
      feed(8'h44);
      step(1'b0, 1'b0, 11'd0, 1'b0, 8'h00, 64'd0);
      feed(8'h55); feed(8'h66);
      idle(1, 64'd0);
      feed(8'h77);
      idle(2, 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, rand_len(),
              $urandom_range(0, 9) < 7, 8'($urandom), rand_pc());
      end

      idle(2, 64'd0);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
